// File: rtl/irq_nest_unit_if.sv
// PC-path bundle between the core's branch/fetch logic and irq_nest_unit.
// The core side (master) drives the PC candidates and control; the unit (slave) returns the final PC.
interface irq_nest_unit_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_next;
   logic              stall;
   logic              end_isr;
   logic [ADDR_W-1:0] pc_next_final;

   modport master (
      output pc, pc_next, stall, end_isr,
      input  pc_next_final
   );

   modport slave (
      input  pc, pc_next, stall, end_isr,
      output pc_next_final
   );
endinterface

// File: rtl/irq_nest_unit.sv
// Nested interrupt controller: pending latches, fixed-priority arbitration, saved-PC/level stack
// and combinational next-PC selection for a sequential-read instruction memory.
module irq_nest_unit #(
   parameter int                NUM_IRQ    = 5,
   parameter int                ADDR_W     = 32,
   parameter int                NEST_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_IRQ-1:0]                irq_n,
   input  logic [NUM_IRQ-1:0]                irq_mask,
   input  logic [NUM_IRQ*ADDR_W-1:0]         irq_vectors,
   irq_nest_unit_if.slave                    bus,
   output logic                              in_isr,
   output logic [$clog2(NUM_IRQ+1)-1:0]      active_level,
   output logic [$clog2(NEST_DEPTH+1)-1:0]   depth,
   output logic [NUM_IRQ-1:0]                pending,
   output logic                              ret_err
);
   localparam int LVL_W = $clog2(NUM_IRQ+1);
   localparam int DEP_W = $clog2(NEST_DEPTH+1);
   localparam logic [LVL_W-1:0] THREAD_LVL = LVL_W'(NUM_IRQ);
   localparam logic [DEP_W-1:0] DEPTH_MAX  = DEP_W'(NEST_DEPTH);

   logic                first_cycle;
   logic [NUM_IRQ-1:0]  pending_next;
   logic [DEP_W-1:0]    depth_next;
   logic [LVL_W-1:0]    level_next;
   logic [ADDR_W-1:0]   vec [NUM_IRQ];
   logic [ADDR_W-1:0]   stack_pc  [NEST_DEPTH];
   logic [LVL_W-1:0]    stack_lvl [NEST_DEPTH];
   logic [LVL_W-1:0]    sel;
   logic [ADDR_W-1:0]   sel_vec;
   logic [ADDR_W-1:0]   top_pc;
   logic [LVL_W-1:0]    top_lvl;
   logic                any_pending;
   logic                take;
   logic                do_pop;
   logic                bad_ret;

   // Per-source vector unpack and pending latch; the source being taken is cleared this edge.
   generate
      for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
         assign vec[gi] = irq_vectors[gi*ADDR_W +: ADDR_W];
         assign pending_next[gi] = irq_mask[gi] & (pending[gi] | ~irq_n[gi])
                                   & ~(take & (sel == LVL_W'(gi)));
      end
   endgenerate

   // Lowest pending index wins; scanning downward lets the lowest index overwrite last.
   always_comb begin
      sel     = THREAD_LVL;
      sel_vec = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pending[i]) begin
            sel     = LVL_W'(i);
            sel_vec = vec[i];
         end
      end
   end

   always_comb begin
      top_pc  = '0;
      top_lvl = THREAD_LVL;
      for (int j = 0; j < NEST_DEPTH; j++) begin
         if (depth == DEP_W'(j + 1)) begin
            top_pc  = stack_pc[j];
            top_lvl = stack_lvl[j];
         end
      end
   end

   assign any_pending = |pending;
   assign take    = !first_cycle && !bus.stall && !bus.end_isr && any_pending
                    && (sel < active_level) && (depth < DEPTH_MAX);
   assign do_pop  = bus.end_isr && !bus.stall && (depth != '0);
   assign bad_ret = bus.end_isr && !bus.stall && (depth == '0);
   assign in_isr  = (depth != '0);

   always_comb begin
      if (first_cycle)
         bus.pc_next_final = RESET_PC;
      else if (bus.stall)
         bus.pc_next_final = bus.pc;
      else if (do_pop)
         bus.pc_next_final = top_pc;
      else if (take)
         bus.pc_next_final = sel_vec;
      else
         bus.pc_next_final = bus.pc_next;
   end

   always_comb begin
      depth_next = depth;
      level_next = active_level;
      if (take) begin
         depth_next = depth + 1'b1;
         level_next = sel;
      end else if (do_pop) begin
         depth_next = depth - 1'b1;
         level_next = top_lvl;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         first_cycle  <= 1'b1;
         pending      <= '0;
         depth        <= '0;
         active_level <= THREAD_LVL;
         ret_err      <= 1'b0;
      end else begin
         first_cycle  <= 1'b0;
         pending      <= pending_next;
         depth        <= depth_next;
         active_level <= level_next;
         if (bad_ret)
            ret_err <= 1'b1;
      end
   end

   // Stack contents need no reset: an entry is only read once depth covers it.
   always_ff @(posedge clk) begin
      for (int j = 0; j < NEST_DEPTH; j++) begin
         if (take && (depth == DEP_W'(j))) begin
            stack_pc[j]  <= bus.pc_next;
            stack_lvl[j] <= active_level;
         end
      end
   end
endmodule

// File: tb/tb_irq_nest_unit.sv
// Directed bench for irq_nest_unit: inputs change 1 time unit after each rising edge,
// outputs are sampled on the falling edge.
module tb_irq_nest_unit;
   localparam int NUM_IRQ = 5;
   localparam int ADDR_W  = 32;

   logic                      clk;
   logic                      reset;
   logic [NUM_IRQ-1:0]        irq_n;
   logic [NUM_IRQ-1:0]        irq_mask;
   logic [NUM_IRQ*ADDR_W-1:0] irq_vectors;
   logic                      in_isr;
   logic [2:0]                active_level;
   logic [1:0]                depth;
   logic [NUM_IRQ-1:0]        pending;
   logic                      ret_err;

   int vectors     = 0;
   int miscompares = 0;

   irq_nest_unit_if #(.ADDR_W(ADDR_W)) bus ();

   irq_nest_unit #(
      .NUM_IRQ    (NUM_IRQ),
      .ADDR_W     (ADDR_W),
      .NEST_DEPTH (2),
      .RESET_PC   (32'h0)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .irq_n        (irq_n),
      .irq_mask     (irq_mask),
      .irq_vectors  (irq_vectors),
      .bus          (bus),
      .in_isr       (in_isr),
      .active_level (active_level),
      .depth        (depth),
      .pending      (pending),
      .ret_err      (ret_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      irq_vectors = {32'h400, 32'h300, 32'h200, 32'h100, 32'h050};
      reset = 1'b0; irq_n = '1; irq_mask = '1;
      bus.pc = '0; bus.pc_next = 32'h10; bus.stall = 1'b0; bus.end_isr = 1'b0;

      #12;
      chk("rst_depth", 32'(depth), 0);
      chk("rst_level", 32'(active_level), 5);
      chk("rst_pending", 32'(pending), 0);
      chk("rst_ret_err", 32'(ret_err), 0);
      #4 reset = 1'b1;
      mid(); chk("first_pc", bus.pc_next_final, 32'h0);
      nc(); mid(); chk("idle_pc", bus.pc_next_final, 32'h10);
      chk("idle_in_isr", 32'(in_isr), 0);
      chk("idle_level", 32'(active_level), 5);

      // Single IRQ3 entry and return
      nc(); irq_n = 5'b10111; bus.pc_next = 32'h40;
      mid(); chk("irq3_req_pc", bus.pc_next_final, 32'h40);
      chk("irq3_req_pend", 32'(pending), 0);
      nc(); irq_n = '1;
      mid(); chk("irq3_take_pc", bus.pc_next_final, 32'h300);
      chk("irq3_take_pend", 32'(pending), 32'h08);
      nc(); bus.pc_next = 32'h304;
      mid(); chk("irq3_depth", 32'(depth), 1);
      chk("irq3_level", 32'(active_level), 3);
      chk("irq3_in_isr", 32'(in_isr), 1);
      chk("irq3_pc", bus.pc_next_final, 32'h304);
      chk("irq3_pend_clr", 32'(pending), 0);
      nc(); bus.end_isr = 1'b1; bus.pc_next = 32'h308;
      mid(); chk("irq3_ret_pc", bus.pc_next_final, 32'h40);
      nc(); bus.end_isr = 1'b0; bus.pc_next = 32'h44;
      mid(); chk("irq3_ret_depth", 32'(depth), 0);
      chk("irq3_ret_level", 32'(active_level), 5);
      chk("irq3_ret_err", 32'(ret_err), 0);
      chk("irq3_ret_idle", bus.pc_next_final, 32'h44);

      // Nesting: IRQ3, then IRQ1, then IRQ4 and IRQ0 held back
      nc(); irq_n = 5'b10111; bus.pc_next = 32'h50;
      mid(); chk("nest_req_pc", bus.pc_next_final, 32'h50);
      nc(); irq_n = '1; bus.pc_next = 32'h60;
      mid(); chk("nest_irq3_pc", bus.pc_next_final, 32'h300);
      nc(); irq_n = 5'b11101; bus.pc_next = 32'h310;
      mid(); chk("nest_in3_pc", bus.pc_next_final, 32'h310);
      chk("nest_in3_level", 32'(active_level), 3);
      nc(); irq_n = '1; bus.pc_next = 32'h314;
      mid(); chk("nest_irq1_pc", bus.pc_next_final, 32'h100);
      nc(); irq_n = 5'b01111; bus.pc_next = 32'h104;
      mid(); chk("nest_depth2", 32'(depth), 2);
      chk("nest_level1", 32'(active_level), 1);
      chk("nest_in1_pc", bus.pc_next_final, 32'h104);
      nc(); irq_n = 5'b11110; bus.pc_next = 32'h108;
      mid(); chk("irq4_pend", 32'(pending), 32'h10);
      chk("irq4_no_take", bus.pc_next_final, 32'h108);
      nc(); irq_n = '1; bus.pc_next = 32'h10C;
      mid(); chk("full_pend", 32'(pending), 32'h11);
      chk("full_no_take", bus.pc_next_final, 32'h10C);
      chk("full_depth", 32'(depth), 2);
      nc(); bus.end_isr = 1'b1; bus.pc_next = 32'h110;
      mid(); chk("ret1_pc", bus.pc_next_final, 32'h314);
      nc(); bus.end_isr = 1'b0; bus.pc_next = 32'h318;
      mid(); chk("ret1_depth", 32'(depth), 1);
      chk("ret1_level", 32'(active_level), 3);
      chk("ret1_pend", 32'(pending), 32'h11);
      chk("irq0_take_pc", bus.pc_next_final, 32'h050);
      nc(); bus.end_isr = 1'b1; bus.pc_next = 32'h054;
      mid(); chk("irq0_depth", 32'(depth), 2);
      chk("irq0_level", 32'(active_level), 0);
      chk("irq0_pend", 32'(pending), 32'h10);
      chk("irq0_ret_pc", bus.pc_next_final, 32'h318);
      nc(); bus.pc_next = 32'h31C;
      mid(); chk("ret3_depth", 32'(depth), 1);
      chk("ret3_level", 32'(active_level), 3);
      chk("ret3_pc", bus.pc_next_final, 32'h60);
      nc(); bus.end_isr = 1'b0; bus.pc_next = 32'h64;
      mid(); chk("irq4_depth0", 32'(depth), 0);
      chk("irq4_level5", 32'(active_level), 5);
      chk("irq4_take_pc", bus.pc_next_final, 32'h400);
      nc(); bus.end_isr = 1'b1; bus.pc_next = 32'h404;
      mid(); chk("irq4_level", 32'(active_level), 4);
      chk("irq4_pend_clr", 32'(pending), 0);
      chk("irq4_ret_pc", bus.pc_next_final, 32'h64);
      nc(); bus.end_isr = 1'b0; bus.pc_next = 32'h68;
      mid(); chk("irq4_ret_depth", 32'(depth), 0);
      chk("irq4_ret_idle", bus.pc_next_final, 32'h68);

      // Capture during stall; end_isr under stall is ignored
      nc(); bus.stall = 1'b1; bus.pc = 32'h80; bus.pc_next = 32'h84; irq_n = 5'b11011;
      mid(); chk("stall1_pc", bus.pc_next_final, 32'h80);
      nc(); irq_n = '1; bus.end_isr = 1'b1;
      mid(); chk("stall2_pc", bus.pc_next_final, 32'h80);
      chk("stall2_pend", 32'(pending), 32'h04);
      nc(); bus.stall = 1'b0; bus.end_isr = 1'b0; bus.pc_next = 32'h88;
      mid(); chk("stall_ret_err", 32'(ret_err), 0);
      chk("stall_pend", 32'(pending), 32'h04);
      chk("irq2_take_pc", bus.pc_next_final, 32'h200);
      nc(); bus.end_isr = 1'b1; bus.pc_next = 32'h204;
      mid(); chk("irq2_depth", 32'(depth), 1);
      chk("irq2_level", 32'(active_level), 2);
      chk("irq2_saved_pc", bus.pc_next_final, 32'h88);
      nc(); bus.end_isr = 1'b0; bus.pc_next = 32'h8C;
      mid(); chk("irq2_ret_depth", 32'(depth), 0);
      chk("irq2_ret_level", 32'(active_level), 5);

      // Return with an empty stack
      nc(); bus.end_isr = 1'b1; bus.pc_next = 32'h24;
      mid(); chk("bad_ret_pc", bus.pc_next_final, 32'h24);
      chk("bad_ret_err0", 32'(ret_err), 0);
      nc(); bus.end_isr = 1'b0; bus.pc_next = 32'h28;
      mid(); chk("bad_ret_err1", 32'(ret_err), 1);
      chk("bad_ret_depth", 32'(depth), 0);
      chk("bad_ret_level", 32'(active_level), 5);
      chk("bad_ret_next", bus.pc_next_final, 32'h28);

      // Clearing the mask discards a pending request
      nc(); irq_n = 5'b11011; bus.stall = 1'b1; bus.pc = 32'h90;
      mid(); chk("err_sticky", 32'(ret_err), 1);
      chk("mask_stall_pc", bus.pc_next_final, 32'h90);
      nc(); irq_n = '1; irq_mask = 5'b11011;
      mid(); chk("mask_pend_set", 32'(pending), 32'h04);
      nc(); bus.stall = 1'b0; irq_mask = '1; bus.pc_next = 32'h2C;
      mid(); chk("mask_pend_clr", 32'(pending), 0);
      chk("mask_no_take", bus.pc_next_final, 32'h2C);

      // Asynchronous reset mid-cycle
      #2 reset = 1'b0;
      #1;
      chk("arst_ret_err", 32'(ret_err), 0);
      chk("arst_depth", 32'(depth), 0);
      chk("arst_pc", bus.pc_next_final, 32'h0);
      reset = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/irq_nest_unit.md
Name: irq_nest_unit

Overview:
- Parametrised successor to the core's inline interrupt/PC-select logic.
- Holds per-source pending latches, fixed-priority arbitration, nested ISR entry with a saved-PC/level stack, and stall-safe IRQ capture.
- Produces the final next-PC combinationally, so the sequential-read instruction memory sees it before the clock edge.
- Sits between the branch control unit (pc_next) and the instruction bus control unit.

Parameters:
- NUM_IRQ, 5, number of interrupt sources; index 0 has the highest priority.
- ADDR_W, 32, PC/vector width.
- NEST_DEPTH, 4, maximum simultaneously active ISRs (stack entries), at least 1.
- RESET_PC, 0, PC presented in the first cycle after reset.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous active-low reset.
- irq_n  input  NUM_IRQ  level IRQ requests, active-low.
- irq_mask  input  NUM_IRQ  1 = source enabled.
- irq_vectors  input  NUM_IRQ*ADDR_W  flattened ISR addresses; slice i is the vector for source i.
- pc  input  ADDR_W  current PC.
- pc_next  input  ADDR_W  next PC from branch logic.
- stall  input  1  multi-cycle instruction in progress.
- end_isr  input  1  return-from-ISR decoded this cycle.
- pc_next_final  output  ADDR_W  PC to load at the next edge (combinational).
- in_isr  output  1  depth != 0.
- active_level  output  $clog2(NUM_IRQ+1)  current priority level; NUM_IRQ = thread level.
- depth  output  $clog2(NEST_DEPTH+1)  stack occupancy.
- pending  output  NUM_IRQ  pending latches.
- ret_err  output  1  sticky: end_isr seen with an empty stack.

Behaviour:
- Reset (async, reset=0): first_cycle=1, pending=0, depth=0, active_level=NUM_IRQ, ret_err=0, stack contents don't-care.
- first_cycle clears at the first clk edge after reset deasserts.
- Pending update, every edge:
  - pending[i] <= mask[i] & (pending[i] | ~irq_n[i]), except the bit of a source taken this cycle, which is cleared.
  - Clearing mask[i] discards pending[i].
  - Capture runs during stall, so no request is lost inside a stalled LW.
- Arbitration (combinational):
  - sel = lowest index i with pending[i]=1.
  - take = !first_cycle & !stall & !end_isr & any pending & sel < active_level & depth < NEST_DEPTH.
- pc_next_final, priority order:
  1. first_cycle -> RESET_PC.
  2. stall -> pc.
  3. end_isr & depth!=0 -> stack[depth-1].pc.
  4. take -> irq_vectors[sel].
  5. else -> pc_next.
- On take:
  - push {pc_next, active_level}.
  - active_level <= sel.
  - depth++.
  - clear pending[sel].
- On end_isr & !stall & depth!=0:
  - pop; active_level <= popped level; depth--.
  - No entry in the same cycle. A pending IRQ is taken the following cycle if still eligible (no tail-chain shortcut).
- end_isr & depth==0 (not stalled): pc_next_final=pc_next, no state change except ret_err <= 1.
- end_isr during stall is ignored; the stall has priority.
- Equal or lower priority than active_level stays pending until the level drops.
- Stack full (depth==NEST_DEPTH): entry blocked, requests remain pending.
- A source held low after entry re-sets its pending bit next cycle. The ISR must clear the device before end_isr, else it re-enters.
- Widths: active_level compare is unsigned; level NUM_IRQ is below every source.

Test Plan:
- Reset then idle, pc_next=0x10 -> cycle0 pc_next_final=0x0 (RESET_PC), cycle1 =0x10; in_isr=0, active_level=5.
- mask=5'b11111, irq_n[3]=0 for 1 cycle, pc_next=0x40, vector3=0x300:
  - next cycle pc_next_final=0x300, depth=1, active_level=3.
  - later end_isr -> 0x40, depth=0, active_level=5.
- Nesting, inside IRQ3 (level 3):
  - assert irq_n[1]=0 -> enters vector1, depth=2, level 1.
  - assert irq_n[4]=0 -> pending[4]=1 held, no entry until both ISRs return, then taken.
- stall=1 for 2 cycles with pc=0x80, irq_n[2] pulsed low in the first stall cycle:
  - pc_next_final=0x80 during stall.
  - pending[2]=1 retained; entry to vector2 in the first non-stall cycle, saved PC = pc_next of that cycle.
- NEST_DEPTH=2 with depth=2, active_level=1, irq_n[0]=0 -> no entry, pending[0]=1 until one return.
- end_isr with depth=0, pc_next=0x24 -> pc_next_final=0x24, ret_err=1 and sticky until reset; end_isr plus pending[0] simultaneously -> return first, entry next cycle.
